// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl
//   Turns the scanner's debounced level outputs into discrete key events (press and,
//   optionally, auto-repeat). Events go into a small show-ahead FIFO that downstream
//   logic drains with rd_en.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     defined   - DELAY/REPEAT timer generates repeat events (key_data[5] = 1)
//     undefined - no timer, no REPEAT state; only press events are produced
//
// Ports:
//   clk       in   system clock (posedge)
//   rst       in   asynchronous active-high reset
//   keyCode   in   [1:0] column, [4:2] row; row 3'h7 means no key
//   ready     in   scanner debounced key-valid level
//   rd_en     in   pop the head entry (ignored when empty)
//   clr_ovf   in   clear the sticky overflow flag
//   key_data  out  FIFO head: [4:0] code, [5] repeat flag
//   empty     out  FIFO empty
//   full      out  FIFO full
//   overflow  out  sticky: an event was dropped on a full FIFO
//   held      out  a valid key is currently held
module keypad_event_ctrl #(
    parameter int unsigned FIFO_AW      = 2,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keyCode,
    input  logic       ready,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [5:0] key_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       held
);

    localparam int unsigned      DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ONE_CNT   = (FIFO_AW + 1)'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;
`else
    // StDelay simply means "key held" when auto-repeat is not built.
    typedef enum logic [0:0] {StIdle, StDelay} state_e;
`endif

    state_e     state_q, state_d;
    logic [4:0] code_q, code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CNT_W-1:0] timer_q, timer_d;
`endif

    logic       valid_key;
    logic       push_req;
    logic [5:0] push_data;

    assign valid_key = ready & (keyCode[4:2] != 3'h7);

    // ------------------------------------------------------------------
    // Event FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        push_req  = 1'b0;
        push_data = 6'h00;
`ifdef KEYPAD_AUTOREPEAT_EN
        timer_d   = timer_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (valid_key) begin
                    push_req  = 1'b1;
                    push_data = {1'b0, keyCode};
                    code_d    = keyCode;
                    state_d   = StDelay;
`ifdef KEYPAD_AUTOREPEAT_EN
                    timer_d   = DELAY_LOAD;
`endif
                end
            end
            default: begin
                if (!valid_key) begin
                    // Release: timer is left frozen, no event.
                    state_d = StIdle;
                end else if (keyCode != code_q) begin
                    // Code changed without release: treat as a fresh press.
                    push_req  = 1'b1;
                    push_data = {1'b0, keyCode};
                    code_d    = keyCode;
                    state_d   = StDelay;
`ifdef KEYPAD_AUTOREPEAT_EN
                    timer_d   = DELAY_LOAD;
                end else if (timer_q == '0) begin
                    push_req  = 1'b1;
                    push_data = {1'b1, code_q};
                    timer_d   = RATE_LOAD;
                    state_d   = StRepeat;
                end else begin
                    timer_d   = timer_q - 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= 5'h00;
`ifdef KEYPAD_AUTOREPEAT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign held = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [5:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_nx;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [5:0]         key_data_q, key_data_d;
    logic               overflow_q, overflow_d;
    logic               do_push, do_pop, ovf_set;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign do_pop    = rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push   = push_req & (~full | do_pop);
    assign ovf_set   = push_req & full & ~do_pop;
    assign rd_ptr_nx = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        key_data_d = key_data_q;
        overflow_d = overflow_q;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_nx;

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Registered head: track what mem[rd_ptr] will be after this edge; hold when
        // the FIFO ends up empty.
        if (empty) begin
            if (do_push) key_data_d = push_data;
        end else if (do_pop) begin
            if (count_q == ONE_CNT) begin
                if (do_push) key_data_d = push_data;
            end else begin
                key_data_d = mem_q[rd_ptr_nx];
            end
        end

        // Set wins over clear.
        if (ovf_set)      overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            key_data_q <= 6'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            key_data_q <= key_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign key_data = key_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl (FIFO_AW=2, REPEAT_DELAY=10, REPEAT_RATE=4).
// Expectations adapt to whether KEYPAD_AUTOREPEAT_EN is defined for the build.
module tb_keypad_event_ctrl;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] keyCode = 5'h00;
    logic       ready = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [5:0] key_data;
    logic       empty, full, overflow, held;

    int checks = 0;
    int failures = 0;

    keypad_event_ctrl #(
        .FIFO_AW      (2),
        .CNT_W        (8),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keyCode  (keyCode),
        .ready    (ready),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .key_data (key_data),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .held     (held)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", held); end
        checks++; if (key_data !== 6'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", key_data); end
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL idle_empty got=%b exp=1", empty); end
    endtask

    task automatic test_press();
        ready = 1'b1;
        keyCode = 5'b01010;
        tick();
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL press_empty got=%b exp=0", empty); end
        checks++; if (key_data !== 6'h0A) begin failures++; $display("FAIL press_data got=%h exp=0a", key_data); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL press_held1 got=%b exp=1", held); end
        tick();
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL press_held2 got=%b exp=1", held); end
        tick();
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL press_held3 got=%b exp=1", held); end
        ready = 1'b0;
        tick();
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL release_held got=%b exp=0", held); end
        checks++; if (key_data !== 6'h0A) begin failures++; $display("FAIL release_data got=%h exp=0a", key_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL press_pop_empty got=%b exp=1", empty); end
        checks++; if (key_data !== 6'h0A) begin failures++; $display("FAIL empty_hold_data got=%h exp=0a", key_data); end
    endtask

    task automatic test_repeat();
        logic [5:0] exp_q [4];
        exp_q[0] = 6'h05; exp_q[1] = 6'h25; exp_q[2] = 6'h25; exp_q[3] = 6'h25;
        ready = 1'b1;
        keyCode = 5'h05;
        tick();
        checks++; if (key_data !== 6'h05) begin failures++; $display("FAIL rep_press got=%h exp=05", key_data); end
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 17) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL rep_full_k17 got=%b exp=0", full); end
            end
            if (k == 18) begin
                checks++; if (full !== 1'b1) begin failures++; $display("FAIL rep_full_k18 got=%b exp=1", full); end
            end
            if (k == 21) begin
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rep_ovf_k21 got=%b exp=0", overflow); end
            end
            if (k == 22) begin
                checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rep_ovf_k22 got=%b exp=1", overflow); end
            end
        end
        ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_data !== exp_q[i]) begin
                failures++; $display("FAIL rep_entry%0d got=%h exp=%h", i, key_data, exp_q[i]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rep_drained got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rep_ovf_sticky got=%b exp=1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rep_clr_ovf got=%b exp=0", overflow); end
`else
        for (int k = 1; k <= 30; k++) tick();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL norep_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL norep_ovf got=%b exp=0", overflow); end
        ready = 1'b0;
        tick();
        checks++; if (key_data !== exp_q[0]) begin failures++; $display("FAIL norep_data got=%h exp=05", key_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL norep_single got=%b exp=1", empty); end
`endif
    endtask

    task automatic test_invalid_row();
        ready = 1'b1;
        keyCode = 5'h1C;
        tick();
        tick();
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL inv_empty got=%b exp=1", empty); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL inv_held got=%b exp=0", held); end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_code_change();
        logic [5:0] exp_head;
        logic       exp_empty;
        exp_head  = AR ? 6'h31 : 6'h11;
        exp_empty = ~AR;
        ready = 1'b1;
        keyCode = 5'h02;
        tick();
        tick();
        tick();
        tick();
        keyCode = 5'h11;
        tick();
        checks++; if (key_data !== 6'h02) begin failures++; $display("FAIL chg_first got=%h exp=02", key_data); end
        rd_en = 1'b1;
        tick();
        checks++; if (key_data !== 6'h11) begin failures++; $display("FAIL chg_second got=%h exp=11", key_data); end
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL chg_drained got=%b exp=1", empty); end
        for (int k = 3; k <= 10; k++) begin
            tick();
            if (k == 9) begin
                checks++; if (empty !== 1'b1) begin failures++; $display("FAIL chg_early_rep got=%b exp=1", empty); end
            end
            if (k == 10) begin
                checks++; if (empty !== exp_empty) begin failures++; $display("FAIL chg_rep_empty got=%b exp=%b", empty, exp_empty); end
                checks++; if (key_data !== exp_head) begin failures++; $display("FAIL chg_rep_data got=%h exp=%h", key_data, exp_head); end
            end
        end
        ready = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL chg_final_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_push_pop();
        logic [5:0] exp_q [4];
        exp_q[0] = 6'h01; exp_q[1] = 6'h02; exp_q[2] = 6'h03; exp_q[3] = 6'h04;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            keyCode = 5'(i);
            tick();
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (key_data !== 6'h00) begin failures++; $display("FAIL fill_head got=%h exp=00", key_data); end
        keyCode = 5'h04;
        rd_en = 1'b1;
        tick();
        checks++; if (key_data !== 6'h01) begin failures++; $display("FAIL pp_head got=%h exp=01", key_data); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL pp_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        rd_en = 1'b0;
        keyCode = 5'h05;
        clr_ovf = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_prio got=%b exp=1", overflow); end
        checks++; if (key_data !== 6'h01) begin failures++; $display("FAIL drop_head got=%h exp=01", key_data); end
        ready = 1'b0;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_data !== exp_q[i]) begin
                failures++; $display("FAIL full_entry%0d got=%h exp=%h", i, key_data, exp_q[i]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty); end
        rd_en = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rd_empty got=%b exp=1", empty); end
        checks++; if (key_data !== 6'h04) begin failures++; $display("FAIL rd_empty_hold got=%h exp=04", key_data); end
        ready = 1'b1;
        keyCode = 5'h07;
        tick();
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL pe_empty got=%b exp=0", empty); end
        checks++; if (key_data !== 6'h07) begin failures++; $display("FAIL pe_data got=%h exp=07", key_data); end
        ready = 1'b0;
        rd_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL pe_count1 got=%b exp=0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pe_drained got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid_hold();
        ready = 1'b1;
        keyCode = 5'h0F;
        tick();
        for (int k = 0; k < 12; k++) tick();
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL mid_held got=%b exp=1", held); end
        rst = 1'b1;
        #2;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%b exp=1", empty); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL rst_mid_held got=%b exp=0", held); end
        checks++; if (key_data !== 6'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", key_data); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%b exp=0", full); end
        rst = 1'b0;
        tick();
        checks++; if (key_data !== 6'h0F) begin failures++; $display("FAIL rst_repress_data got=%h exp=0f", key_data); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL rst_repress_held got=%b exp=1", held); end
        ready = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_one_event got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_repeat();
        test_invalid_row();
        test_code_change();
        test_full_push_pop();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
Sits downstream of the keypad scanner. Converts its debounced level outputs (keyCode, ready) into discrete key events: press and optional auto-repeat. Events are queued in a small show-ahead FIFO that the CPU/display logic drains with a read strobe. It is the block that sequences keypad input for the rest of the design.

Parameters:
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).
CNT_W, 26, width of the repeat timer.
REPEAT_DELAY, 25_000_000, clk cycles from press event to first repeat event; must be >= 1.
REPEAT_RATE, 5_000_000, clk cycles between successive repeat events; must be >= 1.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
keyCode  in  5  scanner key code: [1:0] column, [4:2] row; row 3'h7 = invalid.
ready  in  1  scanner debounced key-valid level.
rd_en  in  1  pop head entry; ignored when empty.
clr_ovf  in  1  clears overflow.
key_data  out  6  FIFO head: [4:0] code, [5] repeat flag (0 = press, 1 = repeat).
empty  out  1  FIFO empty.
full  out  1  FIFO full.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
held  out  1  a valid key is currently held (state != IDLE).

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO pointers and count 0, empty=1, full=0, overflow=0, held=0, key_data=6'h00, latched code 0, timer 0.
- valid_key = ready & (keyCode[4:2] != 3'h7). Inputs are sampled only on posedge clk; no extra synchroniser.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: if valid_key -> push {1'b0, keyCode}, latch keyCode, timer <= REPEAT_DELAY-1, go to DELAY.
  - DELAY / REPEAT: if !valid_key -> IDLE (no event; timer stops).
  - DELAY / REPEAT: if valid_key and keyCode != latched -> push {1'b0, keyCode}, re-latch, timer <= REPEAT_DELAY-1, go to DELAY. This is a new press.
  - DELAY / REPEAT: if valid_key, same code, timer==0 -> push {1'b1, latched}, timer <= REPEAT_RATE-1, go to or stay in REPEAT.
  - Otherwise the timer decrements by 1.
- Timing:
  - Press event is pushed on the same edge at which valid_key is first sampled high in IDLE.
  - empty falls and key_data is valid immediately after that edge (show-ahead, registered).
  - First repeat is pushed REPEAT_DELAY cycles after the press push; subsequent repeats every REPEAT_RATE cycles.
- At most one push per cycle.
- held = (state != IDLE), registered.
- FIFO:
  - key_data always shows the head entry when !empty; it holds its last value when empty.
  - rd_en with empty=1: no effect.
  - Push with full=1 and no pop: entry dropped, pointers unchanged, overflow <= 1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, full stays 1, overflow not set.
  - Push and pop in the same cycle while empty: push succeeds, pop ignored, count becomes 1.
  - Pointers wrap modulo 2**FIFO_AW. full = (count == 2**FIFO_AW), empty = (count == 0); count is FIFO_AW+1 bits.
- overflow: set has priority over clr_ovf in the same cycle.
- Reset asserted mid-hold: all state is cleared. If the key is still held after release of rst, a fresh press event is generated on the first clock edge.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: the full DELAY/REPEAT timer behaviour described above.
- Undefined: timer and REPEAT state are not built; DELAY acts as HELD.
  - Only press events are generated (key_data[5] is always 0).
  - Changed-code and release rules are unchanged.
  - REPEAT_DELAY, REPEAT_RATE and CNT_W are unused.

Test Plan:
Parameters FIFO_AW=2, REPEAT_DELAY=10, REPEAT_RATE=4, KEYPAD_AUTOREPEAT_EN defined.
1. Reset, then ready=1, keyCode=5'b01010 for 3 cycles, then release -> exactly one entry 6'h0A; held high 3 cycles; rd_en one cycle -> empty=1.
2. Hold keyCode=5'h05 for 30 cycles without reading -> press 6'h05 at t0, then 6'h25 at t0+10, t0+14, t0+18 (FIFO full). Further repeats are dropped and overflow=1; clr_ovf -> overflow=0.
3. ready=1, keyCode=5'h1C (row 7) -> no push, held=0.
4. Key 5'h02 held, then code switches to 5'h11 without release -> entries 6'h02 then 6'h11; next repeat of 5'h11 comes 10 cycles after its press.
5. FIFO full plus simultaneous push and rd_en -> head advances, new entry at tail, overflow stays 0. rd_en while empty -> no pointer change.
6. rst pulse mid-REPEAT with the key still held -> outputs return to reset values; one new press event on the first edge after rst deasserts.
